// File: rtl/i2c_cfg_seq.sv
`default_nettype none
// ============================================================================
// i2c_cfg_seq : ROM-driven I2C register-write sequencer with NACK retry,
//               inter-write pacing gap and restart.          Rev 1.0
// ============================================================================
module i2c_cfg_seq #(
  parameter int          DEPTH     = 12,
  parameter int          DATA_W    = 16,
  parameter logic [6:0]  DEV_ADDR  = 7'b0011010,
  parameter int          RETRY_MAX = 3,
  parameter int          DELAY_CYC = 1200,
  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_restart,
  output logic [IDX_W-1:0]  o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_start,
  output logic [6:0]        o_addr,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  input  logic              i_nack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [IDX_W-1:0]  o_fail_idx
);

  localparam int RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int DLY_W = (DELAY_CYC > 0) ? $clog2(DELAY_CYC + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(RETRY_MAX);
  localparam logic [DLY_W-1:0] DLY_LOAD = (DELAY_CYC > 0) ? DLY_W'(DELAY_CYC - 1) : '0;
  localparam bit               HAS_GAP  = (DELAY_CYC > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RTY_W-1:0]    rty_q, rty_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic                rflag_q, rflag_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    fail_q, fail_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rty_q   <= '0;
      dly_q   <= '0;
      rflag_q <= 1'b0;
      data_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rty_q   <= rty_d;
      dly_q   <= dly_d;
      rflag_q <= rflag_d;
      data_q  <= data_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rty_d   = rty_q;
    dly_d   = dly_q;
    rflag_d = rflag_q;
    data_d  = data_q;
    fail_d  = fail_q;
    o_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d   = '0;
        rty_d   = '0;
        rflag_d = 1'b0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        data_d  = i_rom_data;
        state_d = S_START;
      end
      S_START: begin
        o_start = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_ready) begin
          dly_d = DLY_LOAD;
          if (!i_nack) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              rty_d   = '0;
              rflag_d = 1'b0;
              state_d = HAS_GAP ? S_GAP : S_FETCH;
            end
          end else if (rty_q != RTY_LIM) begin
            // Retry resends the held o_data; no ROM re-read needed.
            rty_d   = rty_q + 1'b1;
            rflag_d = 1'b1;
            state_d = HAS_GAP ? S_GAP : S_START;
          end else begin
            fail_d  = idx_q;
            state_d = S_ERROR;
          end
        end
      end
      S_GAP: begin
        if (dly_q == '0) state_d = rflag_q ? S_START : S_FETCH;
        else             dly_d   = dly_q - 1'b1;
      end
      S_DONE, S_ERROR: begin
        if (i_restart) begin
          idx_d   = '0;
          rty_d   = '0;
          rflag_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_rom_addr = idx_q;
  assign o_addr     = DEV_ADDR;
  assign o_data     = data_q;
  assign o_fail_idx = fail_q;
  assign o_busy     = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_START) ||
                      (state_q == S_WAIT)  || (state_q == S_GAP);
  assign o_done     = (state_q == S_DONE);
  assign o_error    = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_i2c_cfg_seq.sv
`default_nettype none
// ============================================================================
// tb_i2c_cfg_seq : scoreboard bench; engine model pushes expected events,
//                  monitor pops them as the DUTs present outputs. Rev 1.0
// ============================================================================
module tb_i2c_cfg_seq;

  localparam int         DEPTH = 12;
  localparam int         RMAX  = 2;
  localparam int         DLY   = 4;
  localparam logic [6:0] DEV   = 7'b0011010;
  localparam int K_START = 0, K_DONE = 1, K_ERR = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] data;
    int          idx;
  } ev_t;

  logic clk = 1'b0, rst = 1'b1, restart = 1'b0, ready = 1'b0, nack = 1'b0, ready1 = 1'b0;
  logic [3:0]  rom_addr, fail_idx;
  logic [15:0] rom_q, o_data, rom1_q, o_data1;
  logic [6:0]  o_addr, o_addr1;
  logic        o_start, o_busy, o_done, o_error;
  logic [0:0]  rom_addr1, fail_idx1;
  logic        o_start1, o_busy1, o_done1, o_error1;

  logic [15:0] rom [16];
  ev_t q[$], q1[$];
  int cyc = 0;
  int checks = 0, errors = 0;
  int ready_at = -1, ready1_at = -1, spur_at = -1, spur_rst_cyc = -1;
  int m_idx = 0, m_try = 0, nack_word = -1, restart_req = 0;
  bit nack_always = 1'b0, spur_en = 1'b0, got_done = 1'b0, got_err = 1'b0;

  i2c_cfg_seq #(.DEPTH(DEPTH), .DATA_W(16), .DEV_ADDR(DEV), .RETRY_MAX(RMAX), .DELAY_CYC(DLY)) dut (
    .i_clk(clk), .i_rst(rst), .i_restart(restart), .o_rom_addr(rom_addr), .i_rom_data(rom_q),
    .o_start(o_start), .o_addr(o_addr), .o_data(o_data), .i_ready(ready), .i_nack(nack),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_fail_idx(fail_idx));

  i2c_cfg_seq #(.DEPTH(1), .DATA_W(16), .DEV_ADDR(DEV), .RETRY_MAX(3), .DELAY_CYC(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_restart(1'b0), .o_rom_addr(rom_addr1), .i_rom_data(rom1_q),
    .o_start(o_start1), .o_addr(o_addr1), .o_data(o_data1), .i_ready(ready1), .i_nack(1'b0),
    .o_busy(o_busy1), .o_done(o_done1), .o_error(o_error1), .o_fail_idx(fail_idx1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q  <= rom[rom_addr];
    rom1_q <= (rom_addr1 == 1'b0) ? 16'h5A5A : 16'hFFFF;
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic ev_t mk(input int kind, input int c, input logic [15:0] d, input int idx);
    ev_t e;
    e.kind = kind; e.cyc = c; e.data = d; e.idx = idx;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Engine model: answers 5 cycles after o_start and predicts the next event.
  task automatic engine_respond();
    bit nk;
    nk = (m_idx == nack_word) && (nack_always || m_try == 0);
    ready = 1'b1;
    nack  = nk;
    if (!nk) begin
      if (m_idx == DEPTH - 1) begin
        q.push_back(mk(K_DONE, cyc + 1, 16'h0, m_idx));
      end else begin
        if (spur_en && m_idx == 1) spur_at = cyc + 2;
        m_idx++;
        m_try = 0;
        q.push_back(mk(K_START, cyc + DLY + 3, rom[m_idx], m_idx));
      end
    end else if (m_try < RMAX) begin
      m_try++;
      q.push_back(mk(K_START, cyc + DLY + 1, rom[m_idx], m_idx));
    end else begin
      q.push_back(mk(K_ERR, cyc + 1, 16'h0, m_idx));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ready = 1'b0; nack = 1'b0; restart = 1'b0; ready1 = 1'b0;
    if (!rst) begin
      if (o_start)  ready_at  = cyc + 5;
      if (o_start1) ready1_at = cyc + 2;
      if (cyc == spur_at) begin ready = 1'b1; nack = 1'b1; end
      if (cyc == spur_rst_cyc) restart = 1'b1;
      if (restart_req != 0) begin
        restart = 1'b1;
        m_idx = 0;
        m_try = 0;
        q.push_back(mk(K_START, cyc + 3, rom[0], 0));
        restart_req = 0;
      end
      if (cyc == ready_at) engine_respond();
      if (cyc == ready1_at) begin
        ready1 = 1'b1;
        q1.push_back(mk(K_DONE, cyc + 1, 16'h0, 0));
      end
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    ready_at = -1; ready1_at = -1; spur_at = -1;
    q.delete(); q1.delete();
    tick();
    chk("rst_start", o_start, 0);   chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);     chk("rst_error", o_error, 0);
    chk("rst_rom_addr", rom_addr, 0); chk("rst_data", o_data, 0);
    chk("rst_fail_idx", fail_idx, 0); chk("rst_addr", o_addr, 26);
    chk("rst1_start", o_start1, 0); chk("rst1_busy", o_busy1, 0);
    chk("rst1_done", o_done1, 0);   chk("rst1_error", o_error1, 0);
    chk("rst1_fail", fail_idx1, 0); chk("rst1_addr", o_addr1, 26);
    rst = 1'b0;
    m_idx = 0; m_try = 0;
    q.push_back(mk(K_START, 3, rom[0], 0));
    q1.push_back(mk(K_START, 3, 16'h5A5A, 0));
  endtask

  task automatic wait_for(input string nm, input int kind, input int bound);
    int n;
    n = 0;
    while (!((kind == K_DONE) ? got_done : got_err) && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, expected kind %0d event", nm, n, kind);
    end
  endtask

  // Monitor: pops one expected event per observed DUT event.
  task automatic pop_cmp(input bit one, input int kind);
    ev_t e;
    int  a_idx, a_data, a_addr, a_busy;
    bit  ok;
    checks++;
    if (kind == K_DONE && !one) got_done = 1'b1;
    if (kind == K_ERR  && !one) got_err  = 1'b1;
    if ((one && q1.size() == 0) || (!one && q.size() == 0)) begin
      errors++;
      $display("FAIL %s_event: got unexpected kind=%0d at cycle %0d, expected none", one ? "dut1" : "dutA", kind, cyc);
      return;
    end
    e = one ? q1.pop_front() : q.pop_front();
    a_idx  = one ? int'(rom_addr1) : ((kind == K_ERR) ? int'(fail_idx) : int'(rom_addr));
    a_data = one ? int'(o_data1) : int'(o_data);
    a_addr = one ? int'(o_addr1) : int'(o_addr);
    a_busy = one ? int'(o_busy1) : int'(o_busy);
    ok = (e.kind == kind) && (e.cyc == cyc) && (a_idx == e.idx);
    if (kind == K_START) ok = ok && (a_data == int'(e.data)) && (a_addr == 26);
    else                 ok = ok && (a_busy == 0);
    if (!ok) begin
      errors++;
      $display("FAIL %s_event: got kind=%0d cyc=%0d idx=%0d data=%h busy=%0d, expected kind=%0d cyc=%0d idx=%0d data=%h",
               one ? "dut1" : "dutA", kind, cyc, a_idx, a_data[15:0], a_busy, e.kind, e.cyc, e.idx, e.data);
    end
  endtask

  initial begin
    bit pd, pe, pd1;
    pd = 1'b0; pe = 1'b0; pd1 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (o_start)           pop_cmp(1'b0, K_START);
        if (o_done && !pd)     pop_cmp(1'b0, K_DONE);
        if (o_error && !pe)    pop_cmp(1'b0, K_ERR);
        if (o_start1)          pop_cmp(1'b1, K_START);
        if (o_done1 && !pd1)   pop_cmp(1'b1, K_DONE);
      end
      pd = o_done; pe = o_error; pd1 = o_done1;
    end
  end

  initial begin
    int n;
    rom[0]  = 16'h1E00; rom[1]  = 16'h0097; rom[2]  = 16'h0297; rom[3]  = 16'h0479;
    rom[4]  = 16'h0679; rom[5]  = 16'h0812; rom[6]  = 16'h0A00; rom[7]  = 16'h0C00;
    rom[8]  = 16'h0E01; rom[9]  = 16'h1000; rom[10] = 16'h1201; rom[11] = 16'h1402;
    for (int i = 12; i < 16; i++) rom[i] = 16'hDEAD;
    tick(); tick();
    do_reset();

    // Nominal run with a NACKed i_ready inside GAP and an i_restart while busy.
    spur_en = 1'b1; spur_rst_cyc = 30; got_done = 1'b0;
    wait_for("nominal_done", K_DONE, 400);
    spur_en = 1'b0; spur_rst_cyc = -1;

    // Single NACK on word 3, retry ACKed.
    nack_word = 3; nack_always = 1'b0; got_done = 1'b0; restart_req = 1;
    wait_for("nack_once_done", K_DONE, 400);

    // Word 5 always NACKs: three attempts then ERROR, then silence.
    nack_word = 5; nack_always = 1'b1; got_err = 1'b0; restart_req = 1;
    wait_for("retry_exhaust_error", K_ERR, 400);
    repeat (40) tick();
    chk("error_held", o_error, 1);
    chk("error_fail_idx", fail_idx, 5);

    // Restart from ERROR with everything ACKed.
    nack_word = -1; nack_always = 1'b0; got_done = 1'b0; restart_req = 1;
    tick();
    tick();
    chk("restart_clears_error", o_error, 0);
    wait_for("restart_done", K_DONE, 400);

    // Reset while waiting on word 7, then a full run from word 0.
    got_done = 1'b0; restart_req = 1;
    n = 0;
    while (!(m_idx == 7 && ready_at > cyc) && n < 400) begin
      tick();
      n++;
    end
    chk("reach_word7_wait", (n < 400) ? 1 : 0, 1);
    do_reset();
    wait_for("post_reset_done", K_DONE, 400);

    repeat (5) tick();
    chk("queue_empty", q.size(), 0);
    chk("queue1_empty", q1.size(), 0);
    chk("final_done", o_done, 1);
    chk("final_done1", o_done1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
